// File: rtl/mau_pkg.sv
// Shared state type, address constants and read-only window helper for mem_access_unit.
package mau_pkg;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        RMW_RD,
        WR,
        RESP
    } mau_state_t;

    localparam logic [7:0] MAU_RO_LO = 8'h4E;
    localparam logic [7:0] MAU_RO_HI = 8'h51;
    localparam logic [7:0] WRAP_ADDR = 8'hFF;

    function automatic logic in_ro_window(input logic [7:0] addr,
                                          input logic [7:0] lo = MAU_RO_LO,
                                          input logic [7:0] hi = MAU_RO_HI);
        return (addr >= lo) && (addr <= hi);
    endfunction

endpackage

// File: rtl/mau_if.sv
// Request/response handshake plus data-memory bus of mem_access_unit.
// master = CPU execute stage and data memory side, slave = the access unit.
interface mau_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 16
);
    logic              req_valid;
    logic              req_ready;
    logic              req_write;
    logic              req_byte;
    logic [ADDR_W-1:0] req_addr;
    logic [DATA_W-1:0] req_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              rsp_err;
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read_en;
    logic              mem_write_en;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport master (
        output req_valid, req_write, req_byte, req_addr, req_wdata, mem_rdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_address, mem_read_en, mem_write_en, mem_wdata
    );

    modport slave (
        input  req_valid, req_write, req_byte, req_addr, req_wdata, mem_rdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err,
               mem_address, mem_read_en, mem_write_en, mem_wdata
    );
endinterface

// File: rtl/mau_sat_counter.sv
// Event counter that sticks at all-ones; synchronous clear.
module mau_sat_counter #(
    parameter int W = 16
) (
    input  logic         i_clk,
    input  logic         i_clr,
    input  logic         i_en,
    output logic [W-1:0] o_count
);
    logic [W-1:0] r_count;

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_count <= '0;
        end else if (i_en && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/mem_access_unit.sv
// Load/store sequencer in front of the data memory; byte stores done as read-modify-write.
// Optional statistics counters are built when MAU_STATS_EN is defined.
//   state  | meaning
//   IDLE   | ready, decode incoming request
//   RD     | one-cycle memory read for a load
//   RMW_RD | read half of a byte store, merge new byte
//   WR     | one-cycle memory write
//   RESP   | one-cycle response pulse
module mem_access_unit
    import mau_pkg::*;
#(
    parameter int         ADDR_W = 8,
    parameter int         DATA_W = 16,
    parameter logic [7:0] RO_LO  = MAU_RO_LO,
    parameter logic [7:0] RO_HI  = MAU_RO_HI
) (
    input  logic        CLK,
    input  logic        RST,
    mau_if.slave        bus,
    output logic [15:0] stat_loads,
    output logic [15:0] stat_stores,
    output logic [15:0] stat_errs
);
    mau_state_t        r_state;
    mau_state_t        w_state_nxt;
    logic              r_write;
    logic              r_byte;
    logic              r_err;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;
    logic [ADDR_W-1:0] w_addr_p1;
    logic              w_err;

    // A byte store rewrites addr+1 as well, so it is checked like a word store.
    assign w_addr_p1 = bus.req_addr + ADDR_W'(1);
    assign w_err = ((bus.req_addr == WRAP_ADDR) && (!bus.req_byte || bus.req_write))
                || (bus.req_write && (in_ro_window(bus.req_addr, RO_LO, RO_HI)
                                   || in_ro_window(w_addr_p1, RO_LO, RO_HI)));

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state <= IDLE;
            r_write <= 1'b0;
            r_byte  <= 1'b0;
            r_err   <= 1'b0;
            r_addr  <= '0;
            r_wdata <= '0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: begin
                    if (bus.req_valid) begin
                        r_write <= bus.req_write;
                        r_byte  <= bus.req_byte;
                        r_addr  <= bus.req_addr;
                        r_wdata <= bus.req_wdata;
                        r_err   <= w_err;
                    end
                end
                RD:      r_rdata <= r_byte ? {8'h00, bus.mem_rdata[DATA_W-1:8]} : bus.mem_rdata;
                RMW_RD:  r_wdata <= {r_wdata[7:0], bus.mem_rdata[7:0]};
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: begin
                if (bus.req_valid) begin
                    if (w_err)              w_state_nxt = RESP;
                    else if (!bus.req_write) w_state_nxt = RD;
                    else if (bus.req_byte)  w_state_nxt = RMW_RD;
                    else                    w_state_nxt = WR;
                end
            end
            RD:      w_state_nxt = RESP;
            RMW_RD:  w_state_nxt = WR;
            WR:      w_state_nxt = RESP;
            RESP:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    assign bus.req_ready    = (r_state == IDLE);
    assign bus.mem_address  = (r_state == IDLE) ? '0 : r_addr;
    assign bus.mem_read_en  = (r_state == RD) || (r_state == RMW_RD);
    assign bus.mem_write_en = (r_state == WR);
    assign bus.mem_wdata    = (r_state == WR) ? r_wdata : '0;
    assign bus.rsp_valid    = (r_state == RESP);
    assign bus.rsp_err      = (r_state == RESP) && r_err;
    assign bus.rsp_rdata    = ((r_state == RESP) && r_write) ? '0 : r_rdata;

`ifdef MAU_STATS_EN
    logic w_resp;
    assign w_resp = (r_state == RESP);

    mau_sat_counter #(.W(16)) u_cnt_loads (
        .i_clk   (CLK),
        .i_clr   (RST),
        .i_en    (w_resp && !r_err && !r_write),
        .o_count (stat_loads)
    );

    mau_sat_counter #(.W(16)) u_cnt_stores (
        .i_clk   (CLK),
        .i_clr   (RST),
        .i_en    (w_resp && !r_err && r_write),
        .o_count (stat_stores)
    );

    mau_sat_counter #(.W(16)) u_cnt_errs (
        .i_clk   (CLK),
        .i_clr   (RST),
        .i_en    (w_resp && r_err),
        .o_count (stat_errs)
    );
`else
    assign stat_loads  = '0;
    assign stat_stores = '0;
    assign stat_errs   = '0;
`endif
endmodule

// File: tb/tb_mem_access_unit.sv
// Directed scoreboard bench for mem_access_unit with a big-endian byte memory model.
module tb_mem_access_unit;

    typedef struct packed {
        logic        err;
        logic        cd;
        logic [15:0] rd;
        logic [31:0] lat;
    } exp_t;

    logic        CLK = 1'b0;
    logic        RST;
    logic [15:0] stat_loads;
    logic [15:0] stat_stores;
    logic [15:0] stat_errs;

    int          n_checks = 0;
    int          n_fail   = 0;
    exp_t        sb[$];
    logic [15:0] last_wdata;

    logic [7:0]  mem [0:255];
    logic        pl_en = 1'b0;
    logic [7:0]  pl_addr = 8'h00;
    logic [7:0]  pl_data = 8'h00;
    logic [7:0]  w_ma1;

    always #5 CLK = ~CLK;

    mau_if bus ();

    mem_access_unit dut (
        .CLK         (CLK),
        .RST         (RST),
        .bus         (bus.slave),
        .stat_loads  (stat_loads),
        .stat_stores (stat_stores),
        .stat_errs   (stat_errs)
    );

    assign w_ma1         = bus.mem_address + 8'd1;
    assign bus.mem_rdata = {mem[bus.mem_address], mem[w_ma1]};

    always @(posedge CLK) begin
        if (pl_en) begin
            mem[pl_addr] <= pl_data;
        end else if (bus.mem_write_en) begin
            mem[bus.mem_address] <= bus.mem_wdata[15:8];
            mem[w_ma1]           <= bus.mem_wdata[7:0];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic pl(input logic [7:0] a, input logic [7:0] d);
        pl_addr = a;
        pl_data = d;
        pl_en   = 1'b1;
        @(posedge CLK);
        #1 pl_en = 1'b0;
    endtask

    // Drive one request, push its expectation, then watch until the response pops it.
    task automatic issue(input string tag, input logic wr, input logic by, input logic [7:0] a,
                         input logic [15:0] wd, input logic e, input logic cd, input logic [15:0] rd,
                         input int lat, input int exp_rd, input int exp_wr);
        exp_t x;
        int   n_rd;
        int   n_wr;
        bit   got;
        n_rd = 0;
        n_wr = 0;
        got  = 1'b0;
        bus.req_valid = 1'b1;
        bus.req_write = wr;
        bus.req_byte  = by;
        bus.req_addr  = a;
        bus.req_wdata = wd;
        @(posedge CLK);
        x.err = e;
        x.cd  = cd;
        x.rd  = rd;
        x.lat = lat;
        sb.push_back(x);
        #1 bus.req_valid = 1'b0;
        for (int n = 1; n <= 12 && !got; n++) begin
            @(negedge CLK);
            if (bus.mem_read_en) n_rd++;
            if (bus.mem_write_en) begin
                n_wr++;
                last_wdata = bus.mem_wdata;
            end
            chk({tag, "_strobe_excl"}, bus.mem_read_en & bus.mem_write_en, 0);
            if (bus.rsp_valid) begin
                got = 1'b1;
                x = sb.pop_front();
                chk({tag, "_err"}, bus.rsp_err, x.err);
                if (x.cd) chk({tag, "_rdata"}, bus.rsp_rdata, x.rd);
                chk({tag, "_lat"}, n, x.lat);
            end
        end
        chk({tag, "_rsp_seen"}, got, 1);
        chk({tag, "_rd_cycles"}, n_rd, exp_rd);
        chk({tag, "_wr_cycles"}, n_wr, exp_wr);
        @(posedge CLK);
        #1;
    endtask

    task automatic quiet(input string tag, input int cycles);
        int n_rsp;
        int n_wr;
        n_rsp = 0;
        n_wr  = 0;
        repeat (cycles) begin
            @(negedge CLK);
            if (bus.rsp_valid) n_rsp++;
            if (bus.mem_write_en) n_wr++;
        end
        chk({tag, "_no_rsp"}, n_rsp, 0);
        chk({tag, "_no_wr"}, n_wr, 0);
        @(posedge CLK);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        RST           = 1'b1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 8'h00;
        bus.req_wdata = 16'h0000;
        last_wdata    = 16'h0000;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;

        chk("rst_req_ready", bus.req_ready, 1);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_err", bus.rsp_err, 0);
        chk("rst_rsp_rdata", bus.rsp_rdata, 0);
        chk("rst_mem_rd", bus.mem_read_en, 0);
        chk("rst_mem_wr", bus.mem_write_en, 0);
        chk("rst_mem_addr", bus.mem_address, 0);
        chk("rst_mem_wdata", bus.mem_wdata, 0);

        pl(8'h20, 8'hAB); pl(8'h21, 8'hCD);
        pl(8'h30, 8'h11); pl(8'h31, 8'h22);
        pl(8'h4C, 8'h44); pl(8'h4D, 8'h77); pl(8'h4E, 8'h88); pl(8'h4F, 8'h99);
        pl(8'hFF, 8'h9C); pl(8'h00, 8'h11);

        issue("ld_word_20", 1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b1, 16'hABCD, 2, 1, 0);

        issue("st_byte_30", 1'b1, 1'b1, 8'h30, 16'hFF5A, 1'b0, 1'b1, 16'h0000, 3, 1, 1);
        chk("rmw_wdata", last_wdata, 16'h5A22);
        chk("mem30_after_rmw", mem[8'h30], 8'h5A);
        chk("mem31_after_rmw", mem[8'h31], 8'h22);

        issue("st_word_4d_ro", 1'b1, 1'b0, 8'h4D, 16'h1234, 1'b1, 1'b0, 16'h0000, 1, 0, 0);
        chk("mem4d_kept", mem[8'h4D], 8'h77);
        chk("mem4e_kept", mem[8'h4E], 8'h88);

        issue("ld_word_ff_wrap", 1'b0, 1'b0, 8'hFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1, 0, 0);
        issue("ld_byte_ff", 1'b0, 1'b1, 8'hFF, 16'h0000, 1'b0, 1'b1, 16'h009C, 2, 1, 0);
        issue("st_byte_ff_wrap", 1'b1, 1'b1, 8'hFF, 16'h00AA, 1'b1, 1'b0, 16'h0000, 1, 0, 0);
        issue("st_byte_4d_ro", 1'b1, 1'b1, 8'h4D, 16'h00AA, 1'b1, 1'b0, 16'h0000, 1, 0, 0);
        issue("st_byte_51_ro", 1'b1, 1'b1, 8'h51, 16'h00AA, 1'b1, 1'b0, 16'h0000, 1, 0, 0);
        issue("ld_word_4e_ro_ok", 1'b0, 1'b0, 8'h4E, 16'h0000, 1'b0, 1'b1, 16'h8899, 2, 1, 0);

        issue("st_byte_4c", 1'b1, 1'b1, 8'h4C, 16'h00E1, 1'b0, 1'b1, 16'h0000, 3, 1, 1);
        chk("mem4c_after_rmw", mem[8'h4C], 8'hE1);
        chk("mem4d_after_rmw", mem[8'h4D], 8'h77);

        issue("st_word_52", 1'b1, 1'b0, 8'h52, 16'hBEEF, 1'b0, 1'b1, 16'h0000, 2, 0, 1);
        chk("mem52", mem[8'h52], 8'hBE);
        chk("mem53", mem[8'h53], 8'hEF);
        issue("ld_word_52", 1'b0, 1'b0, 8'h52, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 2, 1, 0);

        // Reset while the byte store is in its read half: the write must never happen.
        bus.req_valid = 1'b1;
        bus.req_write = 1'b1;
        bus.req_byte  = 1'b1;
        bus.req_addr  = 8'h30;
        bus.req_wdata = 16'h0077;
        @(posedge CLK);
        #1 bus.req_valid = 1'b0;
        chk("rmw_rst_in_read", bus.mem_read_en, 1);
        RST = 1'b1;
        @(posedge CLK);
        #1 RST = 1'b0;
        chk("rmw_rst_ready", bus.req_ready, 1);
        chk("rmw_rst_rd_low", bus.mem_read_en, 0);
        chk("rmw_rst_rdata_clr", bus.rsp_rdata, 0);
        quiet("rmw_rst", 6);
        chk("mem30_kept", mem[8'h30], 8'h5A);
        chk("mem31_kept", mem[8'h31], 8'h22);

        bus.req_valid = 1'b1;
        bus.req_write = 1'b0;
        bus.req_byte  = 1'b0;
        bus.req_addr  = 8'h20;
        RST           = 1'b1;
        @(posedge CLK);
        #1;
        RST           = 1'b0;
        bus.req_valid = 1'b0;
        chk("rst_req_ready_drop", bus.req_ready, 1);
        chk("rst_req_no_rd", bus.mem_read_en, 0);
        quiet("rst_req_drop", 5);

`ifdef MAU_STATS_EN
        chk("stat_loads_clr", stat_loads, 0);
        issue("stat_ld1", 1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b1, 16'hABCD, 2, 1, 0);
        issue("stat_ld2", 1'b0, 1'b1, 8'h20, 16'h0000, 1'b0, 1'b1, 16'h00AB, 2, 1, 0);
        issue("stat_st1", 1'b1, 1'b0, 8'h60, 16'h1234, 1'b0, 1'b1, 16'h0000, 2, 0, 1);
        issue("stat_err1", 1'b0, 1'b0, 8'hFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1, 0, 0);
        chk("stat_loads", stat_loads, 16'd2);
        chk("stat_stores", stat_stores, 16'd1);
        chk("stat_errs", stat_errs, 16'd1);
        force dut.u_cnt_errs.r_count = 16'hFFFF;
        @(posedge CLK);
        #1 release dut.u_cnt_errs.r_count;
        issue("stat_err_sat", 1'b1, 1'b0, 8'h4E, 16'h0000, 1'b1, 1'b0, 16'h0000, 1, 0, 0);
        chk("stat_errs_sat", stat_errs, 16'hFFFF);
        chk("stat_loads_after_sat", stat_loads, 16'd2);
`else
        issue("nostat_ld", 1'b0, 1'b0, 8'h20, 16'h0000, 1'b0, 1'b1, 16'hABCD, 2, 1, 0);
        chk("nostat_loads", stat_loads, 0);
        chk("nostat_stores", stat_stores, 0);
        chk("nostat_errs", stat_errs, 0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
